// File: rtl/rx_slot_ctrl_pkg.sv
// Shared types and defaults for the RX slot ring controller.
// Imported by the controller and its length register file.
package rx_slot_ctrl_pkg;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RECV   = 2'd1,
    S_COMMIT = 2'd2,
    S_DROP   = 2'd3
  } rx_state_t;

  localparam int unsigned DEF_SLOTS      = 4;
  localparam int unsigned DEF_SLOT_BYTES = 2048;
  localparam int unsigned DEF_LEN_W      = 12;
  localparam logic [31:0] RX_MEM_BASE    = 32'h0;

endpackage

// File: rtl/rx_slot_len_rf.sv
// Per-slot frame length storage: one commit write port and
// one registered read port with write bypass and empty clear.
module rx_slot_len_rf
  import rx_slot_ctrl_pkg::*;
#(
  parameter int unsigned SLOTS = DEF_SLOTS,
  parameter int unsigned LEN_W = DEF_LEN_W
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_we,
  input  logic [$clog2(SLOTS)-1:0] i_waddr,
  input  logic [LEN_W-1:0]         i_wdata,
  input  logic [$clog2(SLOTS)-1:0] i_raddr,
  input  logic                     i_clr,
  output logic [LEN_W-1:0]         o_rdata
);

  logic [LEN_W-1:0] r_mem [SLOTS];
  logic [LEN_W-1:0] r_rdata;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i < int'(SLOTS); i++)
        r_mem[i] <= '0;
    end else if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  // Bypass covers a commit landing in the slot that becomes head.
  always_ff @(posedge i_clk) begin
    if (i_rst)
      r_rdata <= '0;
    else if (i_clr)
      r_rdata <= '0;
    else if (i_we && (i_waddr == i_raddr))
      r_rdata <= i_wdata;
    else
      r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/rx_slot_ctrl.sv
// RX memory write sequencer: ring of fixed-size frame slots,
// filter-gated commit, full-ring drop, CPU release and IRQ.
module rx_slot_ctrl
  import rx_slot_ctrl_pkg::*;
#(
  parameter int unsigned SLOTS      = DEF_SLOTS,
  parameter int unsigned SLOT_BYTES = DEF_SLOT_BYTES,
  parameter int unsigned LEN_W      = DEF_LEN_W,
  parameter logic [31:0] MEM_BASE   = RX_MEM_BASE
) (
  input  logic                     RX_CLK,
  input  logic                     rst,
  input  logic                     in_data_v,
  input  logic [7:0]               in_data,
  input  logic                     frame_ok,
  input  logic                     rel_i,
  output logic                     mem_we,
  output logic [31:0]              mem_addr,
  output logic [7:0]               mem_din,
  output logic                     irq,
  output logic [$clog2(SLOTS)-1:0] head_idx,
  output logic [LEN_W-1:0]         head_len,
  output logic [$clog2(SLOTS):0]   count,
  output logic [15:0]              drop_cnt
);

  localparam int IDX_W = $clog2(SLOTS);
  localparam int CNT_W = IDX_W + 1;
  localparam int OFF_W = LEN_W - 1;
  localparam logic [LEN_W-1:0] MAX_OFF = LEN_W'(SLOT_BYTES);
  localparam logic [CNT_W-1:0] FULL = CNT_W'(SLOTS);

  rx_state_t r_state;
  rx_state_t w_state_nx;

  logic             r_prev_v;
  logic [LEN_W-1:0] r_off;
  logic             r_ok;
  logic             r_trunc;
  logic [IDX_W-1:0] r_wr;
  logic [IDX_W-1:0] r_rd;
  logic [CNT_W-1:0] r_cnt;
  logic [15:0]      r_drop;
  logic             r_we;
  logic [31:0]      r_addr;
  logic [7:0]       r_din;

  logic             w_start;
  logic             w_full;
  logic             w_off_max;
  logic             w_wr;
  logic             w_commit;
  logic             w_drop_inc;
  logic             w_ok_set;
  logic             w_trunc_set;
  logic             w_rel;
  logic [IDX_W-1:0] w_rd_nx;
  logic [CNT_W-1:0] w_cnt_nx;

  assign w_start   = in_data_v & ~r_prev_v;
  assign w_full    = (r_cnt == FULL);
  assign w_off_max = (r_off == MAX_OFF);
  assign w_rel     = rel_i & (r_cnt != '0);
  assign w_rd_nx   = r_rd + IDX_W'(w_rel);
  assign w_cnt_nx  = r_cnt + CNT_W'(w_commit)
                   - CNT_W'(w_rel);

  always_ff @(posedge RX_CLK) begin
    if (rst)
      r_state <= S_IDLE;
    else
      r_state <= w_state_nx;
  end

  always_comb begin
    w_state_nx  = r_state;
    w_wr        = 1'b0;
    w_commit    = 1'b0;
    w_drop_inc  = 1'b0;
    w_ok_set    = 1'b0;
    w_trunc_set = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (w_start) begin
          if (w_full) begin
            w_state_nx = S_DROP;
          end else begin
            w_state_nx = S_RECV;
            w_wr       = 1'b1;
            w_ok_set   = frame_ok;
          end
        end
      end
      S_RECV: begin
        w_ok_set = frame_ok;
        if (in_data_v) begin
          if (w_off_max)
            w_trunc_set = 1'b1;
          else
            w_wr = 1'b1;
        end else begin
          w_state_nx = S_COMMIT;
        end
      end
      S_COMMIT: begin
        w_commit   = (r_ok | frame_ok) & ~r_trunc;
        w_drop_inc = ~w_commit;
        // Data already high here means the gap was too short.
        w_state_nx = in_data_v ? S_DROP : S_IDLE;
      end
      S_DROP: begin
        if (!in_data_v) begin
          w_drop_inc = 1'b1;
          w_state_nx = S_IDLE;
        end
      end
      default: w_state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge RX_CLK) begin
    if (rst) begin
      r_prev_v <= 1'b1;
      r_off    <= '0;
      r_ok     <= 1'b0;
      r_trunc  <= 1'b0;
      r_wr     <= '0;
      r_rd     <= '0;
      r_cnt    <= '0;
      r_drop   <= '0;
      r_we     <= 1'b0;
      r_addr   <= '0;
      r_din    <= '0;
    end else begin
      r_prev_v <= in_data_v;
      r_we     <= w_wr;
      if (w_wr) begin
        r_addr <= MEM_BASE
                + (32'(r_wr) << OFF_W)
                + 32'(r_off);
        r_din  <= in_data;
        r_off  <= r_off + 1'b1;
      end
      if (w_ok_set)
        r_ok <= 1'b1;
      if (w_trunc_set)
        r_trunc <= 1'b1;
      if (r_state == S_COMMIT) begin
        r_off   <= '0;
        r_ok    <= 1'b0;
        r_trunc <= 1'b0;
      end
      if (w_commit)
        r_wr <= r_wr + 1'b1;
      r_rd  <= w_rd_nx;
      r_cnt <= w_cnt_nx;
      if (w_drop_inc && (r_drop != 16'hFFFF))
        r_drop <= r_drop + 16'd1;
    end
  end

  rx_slot_len_rf #(
    .SLOTS (SLOTS),
    .LEN_W (LEN_W)
  ) u_len_rf (
    .i_clk   (RX_CLK),
    .i_rst   (rst),
    .i_we    (w_commit),
    .i_waddr (r_wr),
    .i_wdata (r_off),
    .i_raddr (w_rd_nx),
    .i_clr   (w_cnt_nx == '0),
    .o_rdata (head_len)
  );

  assign mem_we   = r_we;
  assign mem_addr = r_addr;
  assign mem_din  = r_din;
  assign irq      = (r_cnt != '0);
  assign head_idx = r_rd;
  assign count    = r_cnt;
  assign drop_cnt = r_drop;

endmodule

// File: tb/tb_rx_slot_ctrl.sv
// Randomized scoreboard bench for rx_slot_ctrl against a
// queue-based model of the slot ring.
module tb_rx_slot_ctrl;

  localparam int SLOTS = 4;
  localparam int SB    = 2048;
  localparam int LEN_W = 12;

  logic        RX_CLK;
  logic        rst;
  logic        in_data_v;
  logic [7:0]  in_data;
  logic        frame_ok;
  logic        rel_i;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [7:0]  mem_din;
  logic        irq;
  logic [1:0]  head_idx;
  logic [11:0] head_len;
  logic [2:0]  count;
  logic [15:0] drop_cnt;

  rx_slot_ctrl #(
    .SLOTS      (SLOTS),
    .SLOT_BYTES (SB),
    .LEN_W      (LEN_W),
    .MEM_BASE   (32'h0)
  ) dut (
    .RX_CLK    (RX_CLK),
    .rst       (rst),
    .in_data_v (in_data_v),
    .in_data   (in_data),
    .frame_ok  (frame_ok),
    .rel_i     (rel_i),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_din   (mem_din),
    .irq       (irq),
    .head_idx  (head_idx),
    .head_len  (head_len),
    .count     (count),
    .drop_cnt  (drop_cnt)
  );

  initial begin
    RX_CLK = 1'b0;
    forever #5 RX_CLK = ~RX_CLK;
  end

  int total = 0;
  int bad   = 0;

  logic [39:0] exp_wr [$];
  int ring_len [$];
  int m_wr;
  int m_rd;
  int m_drop;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
    end
  endtask

  initial begin
    logic [39:0] e;
    forever begin
      @(negedge RX_CLK);
      if (mem_we) begin
        if (exp_wr.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_write addr=%0h din=%0h",
                   mem_addr, mem_din);
        end else begin
          e = exp_wr.pop_front();
          chk("wr_addr", mem_addr, e[39:8]);
          chk("wr_data", {24'h0, mem_din}, {24'h0, e[7:0]});
        end
      end
    end
  end

  task automatic model_reset();
    ring_len.delete();
    m_wr   = 0;
    m_rd   = 0;
    m_drop = 0;
  endtask

  task automatic model_rel();
    if (ring_len.size() > 0) begin
      void'(ring_len.pop_front());
      m_rd = (m_rd + 1) % SLOTS;
    end
  endtask

  task automatic status(input string tag);
    int hl;
    hl = (ring_len.size() > 0) ? ring_len[0] : 0;
    chk({tag, "_count"}, 32'(count), 32'(ring_len.size()));
    chk({tag, "_irq"}, 32'(irq), 32'(ring_len.size() != 0));
    chk({tag, "_head_idx"}, 32'(head_idx), 32'(m_rd));
    chk({tag, "_head_len"}, 32'(head_len), 32'(hl));
    chk({tag, "_drop"}, 32'(drop_cnt), 32'(m_drop));
  endtask

  // okp: byte index of frame_ok, n = first idle cycle,
  // n+1 = commit cycle, -1 = never.
  task automatic send_frame(input int n, input int okp,
                            input bit relc);
    bit acc;
    logic [7:0] b;
    acc = ring_len.size() < SLOTS;
    for (int k = 0; k < n; k++) begin
      @(negedge RX_CLK);
      b = 8'($urandom);
      in_data_v = 1'b1;
      in_data   = b;
      frame_ok  = (k == okp);
      rel_i     = 1'b0;
      if (acc && k < SB)
        exp_wr.push_back({32'(m_wr * SB + k), b});
    end
    @(negedge RX_CLK);
    in_data_v = 1'b0;
    frame_ok  = (okp == n);
    @(negedge RX_CLK);
    frame_ok  = (okp == n + 1);
    rel_i     = relc;
    if (relc)
      model_rel();
    if (acc && okp >= 0 && n <= SB) begin
      ring_len.push_back(n);
      m_wr = (m_wr + 1) % SLOTS;
    end else begin
      m_drop++;
    end
    @(negedge RX_CLK);
    frame_ok = 1'b0;
    rel_i    = 1'b0;
    @(negedge RX_CLK);
  endtask

  task automatic idle_rel();
    @(negedge RX_CLK);
    rel_i = 1'b1;
    model_rel();
    @(negedge RX_CLK);
    rel_i = 1'b0;
    @(negedge RX_CLK);
  endtask

  task automatic rst_frame(input int n, input int ra,
                           input int rb);
    bit acc;
    logic [7:0] b;
    acc = ring_len.size() < SLOTS;
    for (int k = 0; k < n; k++) begin
      @(negedge RX_CLK);
      b = 8'($urandom);
      in_data_v = 1'b1;
      in_data   = b;
      frame_ok  = 1'b1;
      if (k == ra) begin
        rst = 1'b1;
        model_reset();
      end
      if (k == rb)
        rst = 1'b0;
      if (acc && k < ra)
        exp_wr.push_back({32'(m_wr * SB + k), b});
    end
    @(negedge RX_CLK);
    in_data_v = 1'b0;
    frame_ok  = 1'b0;
    repeat (3) @(negedge RX_CLK);
  endtask

  initial begin
    int n;
    int okp;
    rst       = 1'b1;
    in_data_v = 1'b0;
    in_data   = '0;
    frame_ok  = 1'b0;
    rel_i     = 1'b0;
    model_reset();
    repeat (3) @(negedge RX_CLK);
    rst = 1'b0;
    @(negedge RX_CLK);
    chk("rst_we", 32'(mem_we), 32'h0);
    chk("rst_addr", mem_addr, 32'h0);
    status("rst");

    send_frame(64, 63, 1'b0);
    status("f64");

    idle_rel();
    status("rel1");
    for (int i = 0; i < 5; i++)
      send_frame(100, 50, 1'b0);
    status("full");

    idle_rel();
    send_frame(80, 81, 1'b1);
    status("commit_rel");
    send_frame(30, 10, 1'b1);
    status("full_rel");

    repeat (4) idle_rel();
    status("empty");
    send_frame(200, -1, 1'b0);
    status("no_ok");
    send_frame(20, 0, 1'b0);
    status("reuse");

    idle_rel();
    send_frame(SB, SB - 1, 1'b0);
    status("max_len");
    send_frame(SB + 1, 5, 1'b0);
    status("trunc");
    send_frame(8, 9, 1'b0);
    status("after_trunc");

    rst_frame(60, 30, 40);
    status("mid_rst");
    send_frame(16, 3, 1'b0);
    status("post_rst");

    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 9) == 0)
        n = $urandom_range(SB - 2, SB + 2);
      else
        n = $urandom_range(1, 90);
      if ($urandom_range(0, 3) == 0)
        okp = -1;
      else
        okp = $urandom_range(0, n + 1);
      send_frame(n, okp, $urandom_range(0, 2) == 0);
      if ($urandom_range(0, 1) == 0)
        idle_rel();
      status("rnd");
    end

    repeat (3) @(negedge RX_CLK);
    chk("wq_empty", 32'(exp_wr.size()), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
